// File: rtl/conv2_mult_scheduler_if.sv
// Handshake and multiplier-stage bundle for the conv2 multiply scheduler.
// The slave side is the scheduler; the master side is its environment.
interface conv2_mult_scheduler_if #(
    parameter int SUM_W = 20
);
    logic              in_valid;
    logic              in_ready;
    logic [35:0]       in_a;
    logic [35:0]       in_b;
    logic [5:0]        in_mask;
    logic              mult_enable;
    logic [35:0]       mult_a;
    logic [35:0]       mult_b;
    logic [71:0]       mult_p;
    logic              mult_done;
    logic              out_valid;
    logic              out_ready;
    logic [SUM_W-1:0]  out_sum;
    logic              busy;

    modport master (
        output in_valid, in_a, in_b, in_mask, mult_p, mult_done, out_ready,
        input  in_ready, mult_enable, mult_a, mult_b, out_valid, out_sum, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_mask, mult_p, mult_done, out_ready,
        output in_ready, mult_enable, mult_a, mult_b, out_valid, out_sum, busy
    );
endinterface

// File: rtl/conv2_mult_scheduler.sv
// Feeds masked 6-lane operand groups to an external multiplier stage and
// accumulates NUM_GROUPS lane-sum results into one signed dot product.
module conv2_mult_scheduler #(
    parameter int NUM_GROUPS = 4,
    parameter int SUM_W      = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    conv2_mult_scheduler_if.slave  bus
);
    localparam int CNT_W = $clog2(NUM_GROUPS + 1);
    localparam logic [CNT_W-1:0] LAST_GROUP = CNT_W'(NUM_GROUPS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, OUT} state_t;

    state_t                   state_reg, state_next;
    logic signed [SUM_W-1:0]  acc_reg, acc_next;
    logic [CNT_W-1:0]         cnt_reg, cnt_next;
    logic [35:0]              a_reg, b_reg;
    logic [35:0]              a_gated, b_gated;
    logic                     load_ops;
    logic signed [SUM_W-1:0]  lane_ext [6];
    logic signed [SUM_W-1:0]  prod_sum;

    // Inactive lanes are zeroed before they reach the multiplier.
    for (genvar gi = 0; gi < 6; gi++) begin : g_lane
        assign a_gated[6*gi +: 6] = bus.in_mask[gi] ? bus.in_a[6*gi +: 6] : 6'd0;
        assign b_gated[6*gi +: 6] = bus.in_mask[gi] ? bus.in_b[6*gi +: 6] : 6'd0;
        assign lane_ext[gi] = SUM_W'($signed(bus.mult_p[12*gi +: 12]));
    end

    always_comb begin
        prod_sum = '0;
        for (int k = 0; k < 6; k++) begin
            prod_sum = prod_sum + lane_ext[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            if (load_ops) begin
                a_reg <= a_gated;
                b_reg <= b_gated;
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        acc_next        = acc_reg;
        cnt_next        = cnt_reg;
        load_ops        = 1'b0;
        bus.in_ready    = 1'b0;
        bus.mult_enable = 1'b0;
        bus.mult_a      = '0;
        bus.mult_b      = '0;
        bus.out_valid   = 1'b0;
        bus.out_sum     = acc_reg;
        bus.busy        = (state_reg != IDLE);
        case (state_reg)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    load_ops   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                bus.mult_enable = 1'b1;
                bus.mult_a      = a_reg;
                bus.mult_b      = b_reg;
                state_next      = CAPTURE;
            end
            CAPTURE: begin
                bus.mult_enable = 1'b1;
                bus.mult_a      = a_reg;
                bus.mult_b      = b_reg;
                if (bus.mult_done) begin
                    acc_next   = acc_reg + prod_sum;
                    cnt_next   = cnt_reg + 1'b1;
                    state_next = (cnt_reg == LAST_GROUP) ? OUT : IDLE;
                end
            end
            OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    acc_next   = '0;
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_conv2_mult_scheduler.sv
// Directed and random checks of conv2_mult_scheduler against a dot-product model,
// using one 4-group and one 1-group instance with a variable-latency multiplier.
module tb_conv2_mult_scheduler;
    localparam int SUM_W = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int          sel = 0;
    int          mult_dly = 0;
    logic        in_valid_d = 1'b0;
    logic [35:0] in_a_d = '0;
    logic [35:0] in_b_d = '0;
    logic [5:0]  in_mask_d = '0;
    logic        out_ready_d = 1'b0;

    logic             in_ready_v  [2];
    logic             mult_en_v   [2];
    logic [35:0]      mult_a_v    [2];
    logic [35:0]      mult_b_v    [2];
    logic             out_valid_v [2];
    logic [SUM_W-1:0] out_sum_v   [2];
    logic             busy_v      [2];

    conv2_mult_scheduler_if #(.SUM_W(SUM_W)) ifs[2] ();

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        int en_cnt;
        conv2_mult_scheduler #(.NUM_GROUPS(gi == 0 ? 4 : 1), .SUM_W(SUM_W)) u_dut (
            .clk   (clk),
            .reset (rst),
            .bus   (ifs[gi])
        );
        assign ifs[gi].in_valid  = (sel == gi) && in_valid_d;
        assign ifs[gi].in_a      = in_a_d;
        assign ifs[gi].in_b      = in_b_d;
        assign ifs[gi].in_mask   = in_mask_d;
        assign ifs[gi].out_ready = (sel == gi) && out_ready_d;
        assign in_ready_v[gi]  = ifs[gi].in_ready;
        assign mult_en_v[gi]   = ifs[gi].mult_enable;
        assign mult_a_v[gi]    = ifs[gi].mult_a;
        assign mult_b_v[gi]    = ifs[gi].mult_b;
        assign out_valid_v[gi] = ifs[gi].out_valid;
        assign out_sum_v[gi]   = ifs[gi].out_sum;
        assign busy_v[gi]      = ifs[gi].busy;

        // Multiplier stage: done after 1 + mult_dly enabled cycles.
        always @(posedge clk) begin
            if (rst || !ifs[gi].mult_enable || ifs[gi].mult_done) en_cnt <= 0;
            else en_cnt <= en_cnt + 1;
        end
        assign ifs[gi].mult_done = ifs[gi].mult_enable && (en_cnt >= 1 + mult_dly);
        for (genvar gk = 0; gk < 6; gk++) begin : g_mul
            wire signed [11:0] pa = {{6{ifs[gi].mult_a[6*gk+5]}}, ifs[gi].mult_a[6*gk +: 6]};
            wire signed [11:0] pb = {{6{ifs[gi].mult_b[6*gk+5]}}, ifs[gi].mult_b[6*gk +: 6]};
            assign ifs[gi].mult_p[12*gk +: 12] = pa * pb;
        end
    end

    int tests = 0;
    int fails = 0;
    int exp_acc [2] = '{0, 0};
    int exp_cnt [2] = '{0, 0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int ngroups(input int s);
        return (s == 0) ? 4 : 1;
    endfunction

    function automatic int dot(input logic [35:0] a, input logic [35:0] b, input logic [5:0] m);
        int s = 0;
        for (int k = 0; k < 6; k++) begin
            int x = $signed(a[6*k +: 6]);
            int y = $signed(b[6*k +: 6]);
            if (m[k]) s += x * y;
        end
        return s;
    endfunction

    function automatic logic [35:0] gate(input logic [35:0] v, input logic [5:0] m);
        logic [35:0] r = '0;
        for (int k = 0; k < 6; k++) if (m[k]) r[6*k +: 6] = v[6*k +: 6];
        return r;
    endfunction

    function automatic logic [35:0] rand36();
        logic [63:0] r = {$urandom, $urandom};
        return r[35:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_group(input logic [35:0] a, input logic [35:0] b, input logic [5:0] m);
        int t = 0;
        logic [35:0] ea = gate(a, m);
        logic [35:0] eb = gate(b, m);
        while (!in_ready_v[sel] && t < 100) begin tick(); t++; end
        chk("ready_wait", in_ready_v[sel], 1);
        chk("idle_mult_a_zero", mult_a_v[sel], 0);
        chk("idle_mult_b_zero", mult_b_v[sel], 0);
        in_valid_d = 1'b1; in_a_d = a; in_b_d = b; in_mask_d = m;
        tick();
        in_valid_d = 1'b0; in_a_d = rand36(); in_b_d = rand36(); in_mask_d = 6'h3F;
        t = 0;
        while (mult_en_v[sel] && t < 100) begin
            chk("issue_mult_a", mult_a_v[sel], ea);
            chk("issue_mult_b", mult_b_v[sel], eb);
            tick();
            t++;
        end
        chk("enable_cycles", t, 2 + mult_dly);
        exp_acc[sel] += dot(a, b, m);
        exp_cnt[sel]++;
        if (exp_cnt[sel] == ngroups(sel)) chk("out_valid_after_capture", out_valid_v[sel], 1);
        else chk("idle_after_capture", in_ready_v[sel], 1);
    endtask

    task automatic get_result(input int hold);
        int t = 0;
        logic [SUM_W-1:0] es;
        es = SUM_W'(exp_acc[sel]);
        while (!out_valid_v[sel] && t < 100) begin tick(); t++; end
        chk("out_valid_wait", out_valid_v[sel], 1);
        chk("out_sum", out_sum_v[sel], es);
        for (int h = 0; h < hold; h++) begin
            out_ready_d = 1'b0;
            in_valid_d = 1'b1; in_a_d = rand36(); in_b_d = rand36();
            tick();
            chk("stall_out_sum", out_sum_v[sel], es);
            chk("stall_out_valid", out_valid_v[sel], 1);
            chk("stall_in_ready", in_ready_v[sel], 0);
        end
        in_valid_d = 1'b0;
        out_ready_d = 1'b1;
        tick();
        out_ready_d = 1'b0;
        chk("post_out_idle", in_ready_v[sel], 1);
        chk("post_out_valid_low", out_valid_v[sel], 0);
        $display("[TB] inst%0d result sum=%0d hold=%0d", sel, $signed(es), hold);
        exp_acc[sel] = 0;
        exp_cnt[sel] = 0;
    endtask

    task automatic check_reset_state();
        for (int i = 0; i < 2; i++) begin
            chk("rst_in_ready", in_ready_v[i], 1);
            chk("rst_busy", busy_v[i], 0);
            chk("rst_mult_enable", mult_en_v[i], 0);
            chk("rst_out_valid", out_valid_v[i], 0);
            chk("rst_out_sum", out_sum_v[i], 0);
            chk("rst_mult_a", mult_a_v[i], 0);
            exp_acc[i] = 0;
            exp_cnt[i] = 0;
        end
    endtask

    initial begin
        logic [35:0] ra, rb;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check_reset_state();

        // Four unit groups into the 4-group instance: 6*1*2 per group.
        sel = 0; mult_dly = 0;
        for (int g = 0; g < 4; g++) send_group(36'h041041041, 36'h082082082, 6'h3F);
        chk("sum_48", out_sum_v[0], 20'd48);
        get_result(0);

        // Extreme operands on the single-group instance.
        sel = 1;
        send_group(36'h820820820, 36'h820820820, 6'h3F);
        chk("sum_6144", out_sum_v[1], 20'd6144);
        get_result(0);
        send_group(36'h820820820, 36'h7DF7DF7DF, 6'h3F);
        chk("sum_neg5952", out_sum_v[1], 20'hFE8C0);
        get_result(1);

        // Mask 05 gating, then a 5-cycle output stall; next run starts fresh.
        sel = 0;
        for (int g = 0; g < 4; g++) send_group(36'h7FFFFFFFF & 36'h3DF7DF7DF, 36'h1C71C71C7, 6'h05);
        get_result(5);
        for (int g = 0; g < 4; g++) send_group(rand36(), rand36(), 6'h3F);
        get_result(0);

        // Slow multiplier: operands held for the whole capture.
        mult_dly = 3;
        for (int g = 0; g < 4; g++) send_group(rand36(), rand36(), 6'(g + 20));
        get_result(2);
        mult_dly = 0;

        // Reset after two groups with a third in flight.
        send_group(rand36(), rand36(), 6'h3F);
        send_group(rand36(), rand36(), 6'h3F);
        in_valid_d = 1'b1; in_a_d = rand36(); in_b_d = rand36(); in_mask_d = 6'h3F;
        tick();
        in_valid_d = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state();
        for (int g = 0; g < 4; g++) send_group(rand36(), rand36(), 6'h3F);
        get_result(0);

        // Random traffic on both instances.
        for (int r = 0; r < 12; r++) begin
            sel = int'($urandom_range(0, 1));
            for (int g = 0; g < ngroups(sel); g++) begin
                mult_dly = int'($urandom_range(0, 3));
                ra = rand36();
                rb = rand36();
                send_group(ra, rb, 6'($urandom_range(0, 63)));
            end
            get_result(int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/conv2_mult_scheduler.md
CONV2_MULT_SCHEDULER -- requirements
Module: conv2_mult_scheduler

Interface
REQ-001 Parameter NUM_GROUPS, default 4, SHALL set the number of 6-lane operand groups accumulated into one output, legal range 1..16.
REQ-002 Parameter SUM_W, default 20, SHALL set the accumulator and out_sum width.
REQ-003 clk  in  1  single clock; all state SHALL change on its rising edge only.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  operand group offered.
REQ-006 in_ready  out  1  scheduler accepts a group this cycle.
REQ-007 in_a  in  36  six signed 6-bit activations; lane k = bits [6k+5:6k].
REQ-008 in_b  in  36  six signed 6-bit weights, same packing.
REQ-009 in_mask  in  6  lane k active when bit k = 1.
REQ-010 mult_enable  out  1  enable to the 6-lane multiplier stage.
REQ-011 mult_a, mult_b  out  36 each  operands to multiplier inputs 1-6 and 7-12.
REQ-012 mult_p  in  72  six signed 12-bit products; lane k = bits [12k+11:12k].
REQ-013 mult_done  in  1  multiplier stage result valid.
REQ-014 out_valid  out  1  accumulated sum available.
REQ-015 out_ready  in  1  consumer accepts out_sum.
REQ-016 out_sum  out  SUM_W  signed accumulated dot product.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, ISSUE, CAPTURE, and OUT.
REQ-019 in_ready SHALL be 1 only in IDLE; an accept is in_valid && in_ready.
REQ-020 On accept, the block SHALL register in_a and in_b lane-wise with each inactive lane (in_mask bit 0) forced to 0 (operand gating), and SHALL go to ISSUE.
REQ-021 In ISSUE, mult_enable SHALL be 1 and mult_a/mult_b SHALL present the registered operands; the next state SHALL be CAPTURE.
REQ-022 In CAPTURE, mult_enable SHALL stay 1 with unchanged operands until mult_done = 1.
REQ-023 On the CAPTURE cycle with mult_done = 1, acc SHALL become acc + sign-extended sum of all six mult_p lanes, group_cnt SHALL increment, and the next state SHALL be OUT if group_cnt was NUM_GROUPS-1, else IDLE.
REQ-024 In IDLE and OUT, mult_enable SHALL be 0 and mult_a/mult_b SHALL be driven to all zeros.
REQ-025 In OUT, out_valid SHALL be 1 and out_sum SHALL equal acc, held stable until out_ready = 1.
REQ-026 On the OUT cycle with out_ready = 1, acc and group_cnt SHALL clear to 0 and the next state SHALL be IDLE.
REQ-027 Nominal latency SHALL be 2 cycles from accept to accumulate (ISSUE, then CAPTURE with mult_done) and 3 cycles per group in IDLE-ISSUE-CAPTURE.
REQ-028 Arithmetic SHALL be two's complement; the accumulator SHALL wrap modulo 2^SUM_W without saturation.
REQ-029 The block SHALL ignore in_valid outside IDLE and SHALL drop no accepted group.
REQ-030 If NUM_GROUPS = 1, every CAPTURE with mult_done SHALL go to OUT.

Reset
REQ-031 While reset = 1 at a clock edge, the FSM SHALL enter IDLE and acc, group_cnt, registered operands, mult_enable, out_valid, and busy SHALL become 0; in_ready SHALL be 1 after the edge.
REQ-032 Reset SHALL take priority over every other event, including mid-group, mid-CAPTURE, and during an OUT stall; a partial sum SHALL be discarded.

Verification
REQ-033 Reset, then 4 groups with all a = 1, b = 2, mask = 3F, and a model stage with 1-cycle done -> out_sum = 48, out_valid on the cycle after the 4th CAPTURE.
REQ-034 Group with a = -32 and b = -32 on all lanes, NUM_GROUPS = 1 -> out_sum = 6144; with a = -32 and b = 31 -> out_sum = -5952.
REQ-035 mask = 05 with nonzero a/b on all lanes -> mult_a/mult_b lanes 1, 3, 4, and 5 = 0 and the sum includes only lanes 0 and 2; in IDLE, mult_a = mult_b = 0.
REQ-036 Hold out_ready = 0 for 5 cycles in OUT -> out_sum stable, in_ready = 0, and in_valid pulses ignored; out_ready = 1 -> IDLE, with the next result starting from acc = 0.
REQ-037 Delay mult_done by 3 cycles -> mult_enable and operands held through CAPTURE and exactly one accumulation.
REQ-038 Assert reset after 2 of 4 groups -> state IDLE, and a subsequent full 4-group run yields only its own sum.
